// File: rtl/sdram_arbiter_n_pkg.sv
// rtl/sdram_arbiter_n_pkg.sv - shared types and helpers for the N-port SDRAM bridge arbiter
//
// Contents:
//   arb_state_e : arbiter FSM states (ARB_IDLE, ARB_ISSUE, ARB_DONE)
//   arb_op_e    : latched operation of the granted channel (OP_RD, OP_WR)
//   idx_w(n)    : width of a channel index for n channels (never below 1)
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_DONE  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_arbiter_n_rr_picker.sv
// rtl/sdram_arbiter_n_rr_picker.sv - combinational grant picker: fixed high priority, then round robin
//
// Ports:
//   i_active  [N_REQ] : channel has a read or write pending
//   i_hipri   [N_REQ] : channel belongs to the high-priority class
//   i_last    [IW]    : last channel granted from the round-robin pool
//   o_grant   [IW]    : chosen channel
//   o_valid           : at least one channel is active
//   o_from_rr         : the choice came from the round-robin pool
module rr_picker
  import sdram_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_active,
  input  logic [N_REQ-1:0] i_hipri,
  input  logic [IW-1:0]    i_last,
  output logic [IW-1:0]    o_grant,
  output logic             o_valid,
  output logic             o_from_rr
);

  logic [IW-1:0] w_hp_idx;
  logic          w_hp_found;
  logic [IW-1:0] w_rr_idx;
  int            w_best_d;
  int            w_d;

  // Descending scan so the lowest active high-priority index wins.
  always_comb begin
    w_hp_idx   = '0;
    w_hp_found = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (i_active[j] && i_hipri[j]) begin
        w_hp_idx   = IW'(j);
        w_hp_found = 1'b1;
      end
    end
  end

  // w_d is the distance of channel j from last+1 around the ring; the
  // closest active channel is the next one in round-robin order.
  always_comb begin
    w_rr_idx = '0;
    w_best_d = N_REQ;
    w_d      = 0;
    for (int j = 0; j < N_REQ; j++) begin
      w_d = (j + N_REQ - 1 - int'(i_last)) % N_REQ;
      if (i_active[j] && (w_d < w_best_d)) begin
        w_best_d = w_d;
        w_rr_idx = IW'(j);
      end
    end
  end

  assign o_valid   = |i_active;
  assign o_from_rr = ~w_hp_found;
  assign o_grant   = w_hp_found ? w_hp_idx : w_rr_idx;

endmodule

// File: rtl/sdram_arbiter_n.sv
// rtl/sdram_arbiter_n.sv - N-port word arbiter in front of the single SDRAM bridge
//
// Optional feature macro: ARB_TIMEOUT_EN (acknowledge timeout with req_err pulse).
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req_read/req_write  : per-channel request strobes, held until req_ack
//   req_addr/be/wrdata  : packed per-channel address, byte enables, write data
//   req_ack             : one-cycle completion pulse to the owning channel
//   req_rddata          : shared read data, updated only when a read completes
//   req_err             : one-cycle timeout pulse alongside req_ack
//   bridge_*            : single-master bridge interface (address/be/read/write/ack)
//   grant_id            : current or last granted channel
//   busy                : arbiter is not idle
module sdram_arbiter_n
  import sdram_arb_pkg::*;
#(
  parameter int         N_REQ       = 4,
  parameter int         ADDR_W      = 25,
  parameter int         DATA_W      = 16,
  parameter logic [7:0] HIPRI_MASK  = 8'b0000_0010,
  parameter int         TIMEOUT_CYC = 1023,
  localparam int        BE_W        = DATA_W / 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_read,
  input  logic [N_REQ-1:0]           req_write,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*BE_W-1:0]      req_be,
  input  logic [N_REQ*DATA_W-1:0]    req_wrdata,
  output logic [N_REQ-1:0]           req_ack,
  output logic [DATA_W-1:0]          req_rddata,
  output logic [N_REQ-1:0]           req_err,
  output logic [ADDR_W-1:0]          bridge_address,
  output logic [BE_W-1:0]            bridge_byte_enable,
  output logic                       bridge_read,
  output logic                       bridge_write,
  output logic [DATA_W-1:0]          bridge_write_data,
  input  logic                       bridge_acknowledge,
  input  logic [DATA_W-1:0]          bridge_read_data,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int IW = idx_w(N_REQ);

  arb_state_e        r_state;
  arb_op_e           r_op;
  logic [IW-1:0]     r_grant;
  logic [IW-1:0]     r_last;
  logic              r_from_rr;
  logic [ADDR_W-1:0] r_addr;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rddata;
  logic [N_REQ-1:0]  r_ack;

  logic [N_REQ-1:0]  w_active;
  logic [N_REQ-1:0]  w_hipri;
  logic [IW-1:0]     w_grant;
  logic              w_valid;
  logic              w_from_rr;

  assign w_active = req_read | req_write;
  assign w_hipri  = HIPRI_MASK[N_REQ-1:0];

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .i_active  (w_active),
    .i_hipri   (w_hipri),
    .i_last    (r_last),
    .o_grant   (w_grant),
    .o_valid   (w_valid),
    .o_from_rr (w_from_rr)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0]  r_to_cnt;
  logic [N_REQ-1:0] r_err;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ARB_IDLE;
      r_op      <= OP_RD;
      r_grant   <= '0;
      r_last    <= '0;
      r_from_rr <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rddata  <= '0;
      r_ack     <= '0;
`ifdef ARB_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_err     <= '0;
`endif
    end else begin
      // req_ack/req_err are set only on the ISSUE->DONE transition, so
      // they are high exactly during the DONE cycle.
      r_ack <= '0;
`ifdef ARB_TIMEOUT_EN
      r_err <= '0;
`endif
      case (r_state)
        ARB_IDLE: begin
          if (w_valid) begin
            r_grant   <= w_grant;
            r_from_rr <= w_from_rr;
            r_addr    <= req_addr[w_grant*ADDR_W +: ADDR_W];
            r_be      <= req_be[w_grant*BE_W +: BE_W];
            r_wdata   <= req_wrdata[w_grant*DATA_W +: DATA_W];
            // Read+write together resolves to a write.
            r_op      <= req_write[w_grant] ? OP_WR : OP_RD;
            r_state   <= ARB_ISSUE;
`ifdef ARB_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
          end
        end
        ARB_ISSUE: begin
          if (bridge_acknowledge) begin
            if (r_op == OP_RD) begin
              r_rddata <= bridge_read_data;
            end
            r_ack[r_grant] <= 1'b1;
            r_state        <= ARB_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            r_ack[r_grant] <= 1'b1;
            r_err[r_grant] <= 1'b1;
            r_state        <= ARB_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        ARB_DONE: begin
          // High-priority wins leave the fairness pointer alone.
          if (r_from_rr) begin
            r_last <= r_grant;
          end
          r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so a reset drops them on the next edge.
  assign bridge_read        = (r_state == ARB_ISSUE) && (r_op == OP_RD);
  assign bridge_write       = (r_state == ARB_ISSUE) && (r_op == OP_WR);
  assign bridge_address     = r_addr;
  assign bridge_byte_enable = r_be;
  assign bridge_write_data  = r_wdata;
  assign req_ack            = r_ack;
  assign req_rddata         = r_rddata;
  assign grant_id           = r_grant;
  assign busy               = (r_state != ARB_IDLE);

`ifdef ARB_TIMEOUT_EN
  assign req_err = r_err;
`else
  assign req_err = '0;
`endif

endmodule

// File: tb/tb_sdram_arbiter_n.sv
// tb/tb_sdram_arbiter_n.sv - directed self-checking bench for sdram_arbiter_n
module tb_sdram_arbiter_n;
  localparam int N  = 4;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int BW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_read, req_write, req_ack, req_err;
  logic [N*AW-1:0] req_addr;
  logic [N*BW-1:0] req_be;
  logic [N*DW-1:0] req_wrdata;
  logic [DW-1:0]   req_rddata;
  logic [AW-1:0]   bridge_address;
  logic [BW-1:0]   bridge_byte_enable;
  logic            bridge_read, bridge_write;
  logic [DW-1:0]   bridge_write_data;
  logic            bridge_acknowledge;
  logic [DW-1:0]   bridge_read_data;
  logic [1:0]      grant_id;
  logic            busy;

  int vec  = 0;
  int errs = 0;

  // Bridge model: acks on the br_lat-th cycle of a strobe, or never when br_en=0.
  int            br_lat   = 1;
  bit            br_en    = 1'b1;
  bit            br_force = 1'b0;
  int            br_cnt   = 0;
  logic [DW-1:0] br_data  = 16'h0000;

  sdram_arbiter_n #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .HIPRI_MASK(8'b0000_0010), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_be(req_be), .req_wrdata(req_wrdata),
    .req_ack(req_ack), .req_rddata(req_rddata), .req_err(req_err),
    .bridge_address(bridge_address), .bridge_byte_enable(bridge_byte_enable),
    .bridge_read(bridge_read), .bridge_write(bridge_write),
    .bridge_write_data(bridge_write_data), .bridge_acknowledge(bridge_acknowledge),
    .bridge_read_data(bridge_read_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bridge_read || bridge_write) begin
      br_cnt             = br_cnt + 1;
      bridge_acknowledge = br_force || (br_en && br_cnt == br_lat);
      bridge_read_data   = (br_en && br_cnt == br_lat) ? br_data : 16'hDEAD;
    end else begin
      br_cnt             = 0;
      bridge_acknowledge = br_force;
      bridge_read_data   = 16'hDEAD;
    end
  end

  task automatic set_req(input int ch, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
    req_read[ch]             = rd;
    req_write[ch]            = wr;
    req_addr[ch*AW +: AW]    = a;
    req_be[ch*BW +: BW]      = be;
    req_wrdata[ch*DW +: DW]  = d;
  endtask

  task automatic drop(input int ch);
    req_read[ch]  = 1'b0;
    req_write[ch] = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vec++;
    if ({bridge_read, bridge_write, req_ack, req_err, busy, grant_id} !== 12'b0) begin
      errs++;
      $display("FAIL reset_ctl got rd=%b wr=%b ack=%b err=%b busy=%b gid=%0d want all 0",
               bridge_read, bridge_write, req_ack, req_err, busy, grant_id);
    end
    vec++;
    if ({bridge_address, bridge_byte_enable, bridge_write_data, req_rddata} !== 59'b0) begin
      errs++;
      $display("FAIL reset_data got addr=%h be=%b wd=%h rdd=%h want 0",
               bridge_address, bridge_byte_enable, bridge_write_data, req_rddata);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read;
    logic       exp_rd, exp_busy;
    logic [3:0] exp_ack;
    br_lat = 4; br_data = 16'hBEEF; br_en = 1'b1;
    set_req(0, 1'b1, 1'b0, 25'h000123, 2'b11, 16'h0000);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp_rd   = (c <= 4);
      exp_busy = (c <= 5);
      exp_ack  = (c == 5) ? 4'b0001 : 4'b0000;
      vec++;
      if ({bridge_read, bridge_write, req_ack, req_err, busy} !== {exp_rd, 1'b0, exp_ack, 4'b0000, exp_busy}) begin
        errs++;
        $display("FAIL read_seq c=%0d got rd=%b wr=%b ack=%b err=%b busy=%b want rd=%b wr=0 ack=%b err=0000 busy=%b",
                 c, bridge_read, bridge_write, req_ack, req_err, busy, exp_rd, exp_ack, exp_busy);
      end
      if (c <= 4) begin
        vec++;
        if ({bridge_address, bridge_byte_enable} !== {25'h000123, 2'b11}) begin
          errs++;
          $display("FAIL read_addr c=%0d got %h/%b want 000123/11", c, bridge_address, bridge_byte_enable);
        end
      end
      if (c == 5) begin
        vec++;
        if ({req_rddata, grant_id} !== {16'hBEEF, 2'd0}) begin
          errs++;
          $display("FAIL read_data got rdd=%h gid=%0d want BEEF gid=0", req_rddata, grant_id);
        end
        drop(0);
      end
    end
  endtask

  task automatic test_single_write;
    logic       exp_wr, exp_busy;
    logic [3:0] exp_ack;
    br_lat = 2;
    set_req(2, 1'b0, 1'b1, 25'h1ABCDE, 2'b01, 16'h00A5);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp_wr   = (c <= 2);
      exp_busy = (c <= 3);
      exp_ack  = (c == 3) ? 4'b0100 : 4'b0000;
      vec++;
      if ({bridge_read, bridge_write, req_ack, busy} !== {1'b0, exp_wr, exp_ack, exp_busy}) begin
        errs++;
        $display("FAIL write_seq c=%0d got rd=%b wr=%b ack=%b busy=%b want rd=0 wr=%b ack=%b busy=%b",
                 c, bridge_read, bridge_write, req_ack, busy, exp_wr, exp_ack, exp_busy);
      end
      if (c <= 2) begin
        vec++;
        if ({bridge_address, bridge_byte_enable, bridge_write_data} !== {25'h1ABCDE, 2'b01, 16'h00A5}) begin
          errs++;
          $display("FAIL write_bus c=%0d got %h/%b/%h want 1abcde/01/00a5",
                   c, bridge_address, bridge_byte_enable, bridge_write_data);
        end
      end
      if (c == 3) begin
        vec++;
        if ({req_rddata, grant_id} !== {16'hBEEF, 2'd2}) begin
          errs++;
          $display("FAIL write_keep got rdd=%h gid=%0d want BEEF gid=2", req_rddata, grant_id);
        end
        drop(2);
      end
    end
  endtask

  task automatic test_round_robin;
    int got[6];
    int at[6];
    int exp_rr[6] = '{0, 2, 3, 0, 2, 3};
    int n = 0;
    // A lone ch3 transfer parks the fairness pointer at 3.
    br_lat = 1; br_data = 16'h3333;
    set_req(3, 1'b1, 1'b0, 25'h000333, 2'b11, 16'h0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 2) begin
        vec++;
        if ({req_ack, req_rddata} !== {4'b1000, 16'h3333}) begin
          errs++;
          $display("FAIL rr_prime got ack=%b rdd=%h want 1000/3333", req_ack, req_rddata);
        end
        drop(3);
      end
    end
    br_data = 16'h5A5A;
    for (int i = 0; i < 6; i++) begin got[i] = -1; at[i] = -1; end
    set_req(0, 1'b1, 1'b0, 25'h000010, 2'b11, 16'h0);
    set_req(2, 1'b1, 1'b0, 25'h000020, 2'b11, 16'h0);
    set_req(3, 1'b1, 1'b0, 25'h000030, 2'b11, 16'h0);
    for (int cyc = 1; cyc <= 60 && n < 6; cyc++) begin
      @(negedge clk);
      if (req_ack != 4'b0000) begin
        got[n] = int'(grant_id);
        at[n]  = cyc;
        vec++;
        if (req_ack !== (4'b0001 << grant_id)) begin
          errs++;
          $display("FAIL rr_onehot got ack=%b gid=%0d", req_ack, grant_id);
        end
        n++;
      end
    end
    drop(0); drop(2); drop(3);
    vec++;
    if (n != 6) begin
      errs++;
      $display("FAIL rr_timeout got %0d grants want 6", n);
    end
    for (int i = 0; i < 6; i++) begin
      vec++;
      if (got[i] != exp_rr[i]) begin
        errs++;
        $display("FAIL rr_order idx=%0d got %0d want %0d", i, got[i], exp_rr[i]);
      end
    end
    for (int i = 1; i < 6; i++) begin
      vec++;
      if (at[i] - at[i-1] != 3) begin
        errs++;
        $display("FAIL rr_period idx=%0d got %0d want 3", i, at[i] - at[i-1]);
      end
    end
    @(negedge clk);
    vec++;
    if ({busy, req_rddata} !== {1'b0, 16'h5A5A}) begin
      errs++;
      $display("FAIL rr_end got busy=%b rdd=%h want 0/5a5a", busy, req_rddata);
    end
  endtask

  task automatic test_priority;
    int got[4];
    int exp_pr[4] = '{1, 1, 0, 2};
    int n = 0;
    int g;
    br_lat = 1; br_data = 16'h7E7E;
    for (int i = 0; i < 4; i++) got[i] = -1;
    set_req(0, 1'b1, 1'b0, 25'h000100, 2'b11, 16'h0);
    set_req(1, 1'b1, 1'b0, 25'h000101, 2'b11, 16'h0);
    for (int cyc = 1; cyc <= 60 && n < 4; cyc++) begin
      @(negedge clk);
      if (req_ack != 4'b0000) begin
        g = int'(grant_id);
        got[n] = g;
        n++;
        // After ch1's second win it leaves and ch2 joins; the rr pointer
        // (still 3) must then pick ch0 ahead of ch2.
        if (n == 2) begin
          drop(1);
          set_req(2, 1'b1, 1'b0, 25'h000102, 2'b11, 16'h0);
        end
        if (g == 0) drop(0);
        if (g == 2) drop(2);
      end
    end
    drop(0); drop(1); drop(2);
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (got[i] != exp_pr[i]) begin
        errs++;
        $display("FAIL prio_order idx=%0d got %0d want %0d", i, got[i], exp_pr[i]);
      end
    end
    @(negedge clk);
    vec++;
    if ({busy, req_rddata} !== {1'b0, 16'h7E7E}) begin
      errs++;
      $display("FAIL prio_end got busy=%b rdd=%h want 0/7e7e", busy, req_rddata);
    end
  endtask

  task automatic test_timeout;
    logic       exp_rd, exp_busy;
    logic [3:0] exp_ack;
    br_en = 1'b0;
    set_req(2, 1'b1, 1'b0, 25'h000222, 2'b11, 16'h0);
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      exp_rd   = (c <= 8);
      exp_busy = (c <= 9);
      exp_ack  = (c == 9) ? 4'b0100 : 4'b0000;
      vec++;
      if ({bridge_read, req_ack, req_err, busy} !== {exp_rd, exp_ack, exp_ack, exp_busy}) begin
        errs++;
        $display("FAIL timeout_seq c=%0d got rd=%b ack=%b err=%b busy=%b want rd=%b ack=%b err=%b busy=%b",
                 c, bridge_read, req_ack, req_err, busy, exp_rd, exp_ack, exp_ack, exp_busy);
      end
      if (c == 9) begin
        vec++;
        if (req_rddata !== 16'h7E7E) begin
          errs++;
          $display("FAIL timeout_rdd got %h want 7e7e", req_rddata);
        end
        drop(2);
      end
    end
`else
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      exp_rd   = 1'b1;
      exp_busy = 1'b1;
      exp_ack  = 4'b0000;
      vec++;
      if ({bridge_read, req_ack, req_err, busy} !== {exp_rd, exp_ack, exp_ack, exp_busy}) begin
        errs++;
        $display("FAIL hang_seq c=%0d got rd=%b ack=%b err=%b busy=%b want rd=1 ack=0000 err=0000 busy=1",
                 c, bridge_read, req_ack, req_err, busy);
      end
    end
    reset = 1'b1;
    drop(2);
    @(negedge clk);
    reset = 1'b0;
`endif
    br_en = 1'b1;
  endtask

  task automatic test_reset_mid_issue;
    logic       exp_wr, exp_busy;
    logic [3:0] exp_ack;
    br_en = 1'b0;
    set_req(3, 1'b1, 1'b0, 25'h000777, 2'b11, 16'h0);
    repeat (2) @(negedge clk);
    vec++;
    if ({bridge_read, grant_id} !== {1'b1, 2'd3}) begin
      errs++;
      $display("FAIL rst_pre got rd=%b gid=%0d want 1/3", bridge_read, grant_id);
    end
    reset = 1'b1;
    drop(3);
    @(negedge clk);
    vec++;
    if ({bridge_read, bridge_write, busy, grant_id, req_ack, req_rddata} !== 25'b0) begin
      errs++;
      $display("FAIL rst_mid got rd=%b wr=%b busy=%b gid=%0d ack=%b rdd=%h want all 0",
               bridge_read, bridge_write, busy, grant_id, req_ack, req_rddata);
    end
    reset = 1'b0;
    br_en = 1'b1; br_lat = 2;
    set_req(1, 1'b0, 1'b1, 25'h0000FF, 2'b10, 16'h1234);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp_wr   = (c <= 2);
      exp_busy = (c <= 3);
      exp_ack  = (c == 3) ? 4'b0010 : 4'b0000;
      vec++;
      if ({bridge_write, req_ack, busy} !== {exp_wr, exp_ack, exp_busy}) begin
        errs++;
        $display("FAIL rst_after c=%0d got wr=%b ack=%b busy=%b want wr=%b ack=%b busy=%b",
                 c, bridge_write, req_ack, busy, exp_wr, exp_ack, exp_busy);
      end
      if (c == 1) begin
        vec++;
        if ({bridge_address, bridge_byte_enable, bridge_write_data} !== {25'h0000FF, 2'b10, 16'h1234}) begin
          errs++;
          $display("FAIL rst_after_bus got %h/%b/%h want 0000ff/10/1234",
                   bridge_address, bridge_byte_enable, bridge_write_data);
        end
      end
      if (c == 3) drop(1);
    end
  endtask

  task automatic test_stray_ack;
    br_force = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      vec++;
      if ({req_ack, busy, bridge_read, bridge_write, req_rddata} !== {4'b0000, 3'b000, 16'h0000}) begin
        errs++;
        $display("FAIL stray_ack c=%0d got ack=%b busy=%b rd=%b wr=%b rdd=%h want 0",
                 c, req_ack, busy, bridge_read, bridge_write, req_rddata);
      end
    end
    br_force = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset              = 1'b1;
    req_read           = '0;
    req_write          = '0;
    req_addr           = '0;
    req_be             = '0;
    req_wrdata         = '0;
    bridge_acknowledge = 1'b0;
    bridge_read_data   = '0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_priority();
    test_timeout();
    test_reset_mid_issue();
    test_stray_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter_n.md
Name: sdram_arbiter_n

Overview:
Parametrised N-port arbiter that multiplexes independent word requestors (SD-card loader, I2S audio fetch, sprite/background fetch, NIOS-side helpers) onto the single SDRAM external-bus bridge (address/byte-enable/read/write/acknowledge).
- Successor to the fixed two-client SD-init/I2S arbiter.
- Generalised in client count, address/data width and priority mode.
- Adds a per-client high-priority mask, round-robin fairness, latched read data and a grant-ID/busy status.

Parameters:
N_REQ, 4, number of requestor channels (2..8)
ADDR_W, 25, word address width
DATA_W, 16, data width; byte-enable width BE_W = DATA_W/8
HIPRI_MASK, 4'b0010, bit i set = channel i is high priority (beats round-robin)
TIMEOUT_CYC, 1023, acknowledge timeout in clk cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
req_read  in  N_REQ  per-channel read request, held until req_ack
req_write  in  N_REQ  per-channel write request, held until req_ack
req_addr  in  N_REQ*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
req_be  in  N_REQ*BE_W  packed byte enables
req_wrdata  in  N_REQ*DATA_W  packed write data
req_ack  out  N_REQ  one-cycle completion pulse to the owning channel
req_rddata  out  DATA_W  shared read data, valid when req_ack[i] pulses after a read
req_err  out  N_REQ  one-cycle timeout pulse, coincident with req_ack (ARB_TIMEOUT_EN only, else 0)
bridge_address  out  ADDR_W  word address to bridge (top level appends the byte LSB 0)
bridge_byte_enable  out  BE_W  byte enables
bridge_read  out  1  read strobe
bridge_write  out  1  write strobe
bridge_write_data  out  DATA_W  write data
bridge_acknowledge  in  1  transfer complete; read data valid in this cycle
bridge_read_data  in  DATA_W  read data
grant_id  out  $clog2(N_REQ)  index of current/last granted channel
busy  out  1  high while state != IDLE

Behaviour:
- Reset values: all strobes 0, req_ack 0, req_err 0, req_rddata 0, bridge address/data/be 0, grant_id 0, busy 0, rr pointer 0, state IDLE.
- States: IDLE -> ISSUE -> DONE -> IDLE.
- IDLE:
  - active[i] = req_read[i] | req_write[i].
  - If any active high-priority channel exists, grant the lowest such index.
  - Otherwise grant round-robin: search starts at last_grant+1 and wraps modulo N_REQ.
  - On grant, register addr/be/wrdata/op into the bridge outputs, set grant_id, go to ISSUE.
  - A channel with both read and write set is treated as a write.
- ISSUE:
  - Hold bridge_read or bridge_write plus address/data stable until bridge_acknowledge.
  - On acknowledge, latch bridge_read_data into req_rddata (reads only), drop strobes, go to DONE.
- DONE:
  - Pulse req_ack[grant_id] for one cycle.
  - Update last_grant only when the grant came from the round-robin pool, so high-priority wins do not disturb fairness.
  - Return to IDLE.
  - The requestor must deassert in the cycle after req_ack. A request still held in IDLE is a new transfer.
- Latency: request seen in IDLE at cycle 0; strobe asserted at cycle 1; acknowledge at cycle k; req_ack at cycle k+1. Minimum back-to-back period is 3 cycles plus bridge latency.
- Requests arriving during ISSUE/DONE wait; they are never lost and never preempt.
- Requests from non-granted channels are ignored until IDLE.
- An acknowledge seen in IDLE or DONE is ignored.
- Reset mid-ISSUE: strobes drop on the next edge and the transfer is abandoned with no req_ack. The bridge must tolerate this.
- req_rddata holds its value until the next read completes.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A counter runs in ISSUE; at TIMEOUT_CYC without acknowledge, strobes drop and the state goes to DONE.
  - DONE pulses req_ack and req_err for that channel; req_rddata is left unchanged.
- Undefined: no counter; ISSUE waits indefinitely; req_err is tied 0.

Decomposition:
- Package sdram_arb_pkg: state enum (ARB_IDLE, ARB_ISSUE, ARB_DONE), op enum (OP_RD, OP_WR), function idx_w(n) = $clog2(n).
- One sub-module, rr_picker (combinational): inputs active vector, high-priority mask and last_grant; outputs grant index, valid and from_rr flag.

Test Plan:
- Single read: ch0 read addr 0x000123, bridge acks 4 cycles after strobe with 0xBEEF -> req_ack[0] pulses at cycle 5 with req_rddata=0xBEEF; bridge_read high cycles 1-4.
- Single write: ch2 write addr 0x1ABCDE, be=2'b01, data 0x00A5 -> bridge_write high with exact address/be/data until ack; req_ack[2] one cycle; no other ack.
- Round robin: ch0, ch2 and ch3 (all low priority) request continuously with 1-cycle acks -> grant order 0,2,3,0,2,3; no starvation.
- Priority: HIPRI_MASK=0010, ch1 and ch0 request together repeatedly -> ch1 wins every contention; ch0 is served whenever ch1 is idle; rr pointer is unchanged by ch1 grants.
- Reset mid-ISSUE: assert reset while bridge_read=1 -> the next edge shows all strobes 0, busy 0 and grant_id 0, with no req_ack; a subsequent request completes normally.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYC=8): bridge never acks -> strobe drops after 8 cycles; req_ack[i] and req_err[i] pulse together; req_rddata is unchanged.
